pl_imem_sync: RTL and testbench

PL_IMEM_SYNC -- requirements
Module: pl_imem_sync

---
 rtl/pl_imem_sync.sv | 99 +++++++++
 tb/tb_pl_imem_sync.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_imem_sync.sv
// Instruction memory with a LOAD/RUN program-load FSM and a one-cycle
// registered fetch port that flags misaligned or out-of-range PCs.
module pl_imem_sync #(
    parameter int                DEPTH_LOG2 = 5,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_INST   = 32'h00000013,
    parameter bit                BOOT_RUN   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc,
    input  logic                  fetch,
    input  logic                  stall,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  go,
    input  logic                  halt,
    output logic [DATA_W-1:0]     inst,
    output logic                  inst_valid,
    output logic                  fault,
    output logic                  running,
    output logic [DEPTH_LOG2:0]   load_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] COUNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    accept;
    logic                    bad_pc;
    logic                    load_write;

    // Fetch handshake: fetch acts as valid and (running && !stall) as ready;
    // a fetch is accepted only in a cycle where both are high, and its result
    // appears on inst/inst_valid/fault after that edge, held while stalled.
    assign accept     = (state == RUN) && fetch && !stall;
    assign word_idx   = pc[DEPTH_LOG2+1:2];
    assign bad_pc     = (pc[1:0] != 2'b00) || ((pc >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign load_write = (state == LOAD) && load_en && !rst;
    assign running    = (state == RUN);

    // No reset on the array: a program survives reset and reloads are partial.
    always_ff @(posedge clk) begin
        if (load_write) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT_RUN ? RUN : LOAD;
            load_count <= '0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            if (!stall) begin
                if (accept) begin
                    inst       <= bad_pc ? NOP_INST : mem[word_idx];
                    inst_valid <= 1'b1;
                    fault      <= bad_pc;
                end else begin
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                    fault      <= 1'b0;
                end
            end

            case (state)
                LOAD: begin
                    if (load_en && (load_count != COUNT_MAX)) begin
                        load_count <= load_count + COUNT_ONE;
                    end
                    if (go) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The count restarts at the moment LOAD is re-entered.
                    if (halt) begin
                        state      <= LOAD;
                        load_count <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_imem_sync.sv
// Bench for pl_imem_sync: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch/load rules.
module tb_pl_imem_sync;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, fetch, stall, load_en, go, halt;
    logic [31:0] pc;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] inst;
    logic        inst_valid, fault, running;
    logic [5:0]  load_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    // behavioural model state
    bit          m_run;
    int          m_cnt;
    logic [31:0] m_inst;
    bit          m_valid, m_fault;
    logic [31:0] m_mem [32];

    pl_imem_sync dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch(fetch), .stall(stall),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .go(go), .halt(halt), .inst(inst), .inst_valid(inst_valid),
        .fault(fault), .running(running), .load_count(load_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Model: inputs are stable at the rising edge, so read them directly.
    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_inst = NOP; m_valid = 1'b0; m_fault = 1'b0;
        end else begin
            if (!stall) begin
                if (m_run && fetch) begin
                    m_valid = 1'b1;
                    if ((pc % 4) != 0 || pc >= 32'd128) begin
                        m_inst = NOP; m_fault = 1'b1;
                    end else begin
                        m_inst = m_mem[pc / 4]; m_fault = 1'b0;
                    end
                end else begin
                    m_inst = NOP; m_valid = 1'b0; m_fault = 1'b0;
                end
            end
            if (!m_run) begin
                if (load_en) begin
                    m_mem[load_addr] = load_data;
                    if (m_cnt < 32) m_cnt = m_cnt + 1;
                end
                if (go) m_run = 1'b1;
            end else if (halt) begin
                m_run = 1'b0; m_cnt = 0;
            end
        end
    end

    // driver tasks
    task automatic drive_idle();
        rst = 0; fetch = 0; stall = 0; load_en = 0; go = 0; halt = 0;
        pc = 0; load_addr = 0; load_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checks++; if (inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
        checks++; if (load_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", load_count); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    endtask

    task automatic test_load_go();
        logic [31:0] prog [4];
        prog[0] = 32'h00100093; prog[1] = 32'h04008213;
        prog[2] = 32'h00022483; prog[3] = 32'h404484B3;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            load_en = 1; load_addr = 5'(i); load_data = prog[i];
            tick();
        end
        drive_idle();
        go = 1;
        tick();
        go = 0;
        checks++; if (load_count !== 6'd4) begin failures++; $display("FAIL load_count got=%0d exp=4", load_count); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL go_running got=%b exp=1", running); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        drive_idle();
        exp_q.push_back(32'h00022483);
        exp_q.push_back(32'h404484B3);
        for (int i = 0; i < 2; i++) begin
            fetch = 1; pc = 32'h8 + 32'(4 * i);
            tick();
            exp = exp_q.pop_front();
            checks++; if (inst !== exp) begin failures++; $display("FAIL b2b_inst%0d got=%h exp=%h", i, inst, exp); end
            checks++; if (inst_valid !== 1'b1 || fault !== 1'b0) begin
                failures++; $display("FAIL b2b_flags%0d got=%b%b exp=10", i, inst_valid, fault);
            end
        end
        drive_idle();
    endtask

    task automatic test_fault();
        logic [31:0] bad_pcs [3];
        bad_pcs[0] = 32'h6; bad_pcs[1] = 32'h80; bad_pcs[2] = 32'h1000_0000;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            fetch = 1; pc = bad_pcs[i];
            tick();
            checks++; if (inst !== NOP || fault !== 1'b1 || inst_valid !== 1'b1) begin
                failures++;
                $display("FAIL fault_pc%h got=%h f=%b v=%b exp=%h f=1 v=1", bad_pcs[i], inst, fault, inst_valid, NOP);
            end
        end
        drive_idle();
    endtask

    task automatic test_stall();
        drive_idle();
        fetch = 1; pc = 32'h4;
        tick();
        checks++; if (inst !== 32'h04008213) begin failures++; $display("FAIL stall_first got=%h exp=04008213", inst); end
        for (int i = 0; i < 3; i++) begin
            stall = 1; fetch = 1'($urandom_range(0, 1)); pc = {$urandom_range(0, 31), 2'b00};
            tick();
            checks++; if (inst !== 32'h04008213 || inst_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got=%h v=%b exp=04008213 v=1", i, inst, inst_valid);
            end
        end
        drive_idle();
        tick();
        checks++; if (inst !== NOP || inst_valid !== 1'b0 || fault !== 1'b0) begin
            failures++; $display("FAIL idle_fetch got=%h v=%b f=%b exp=%h v=0 f=0", inst, inst_valid, fault, NOP);
        end
    endtask

    task automatic test_run_load_ignored();
        drive_idle();
        load_en = 1; load_addr = 0; load_data = 32'hFFFFFFFF;
        tick();
        drive_idle();
        fetch = 1; pc = 32'h0;
        tick();
        drive_idle();
        checks++; if (inst !== 32'h00100093) begin failures++; $display("FAIL run_load_inst got=%h exp=00100093", inst); end
        checks++; if (load_count !== 6'd4) begin failures++; $display("FAIL run_load_count got=%0d exp=4", load_count); end
    endtask

    task automatic test_saturate_halt();
        logic [31:0] wd [32];
        drive_idle();
        halt = 1;
        tick();
        drive_idle();
        checks++; if (running !== 1'b0 || load_count !== 6'd0) begin
            failures++; $display("FAIL halt_entry got=r%b c%0d exp=r0 c0", running, load_count);
        end
        for (int i = 0; i < 40; i++) begin
            load_en = 1; load_addr = 5'(i % 32); load_data = $urandom; go = (i == 39);
            wd[i % 32] = load_data;
            tick();
        end
        drive_idle();
        checks++; if (load_count !== 6'd32) begin failures++; $display("FAIL saturate got=%0d exp=32", load_count); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL load_go_same got=%b exp=1", running); end
        halt = 1; fetch = 1; pc = 32'h1C;
        tick();
        drive_idle();
        checks++; if (inst !== wd[7] || inst_valid !== 1'b1 || fault !== 1'b0) begin
            failures++; $display("FAIL halt_fetch got=%h v=%b f=%b exp=%h v=1 f=0", inst, inst_valid, fault, wd[7]);
        end
        checks++; if (running !== 1'b0 || load_count !== 6'd0) begin
            failures++; $display("FAIL halt_state got=r%b c%0d exp=r0 c0", running, load_count);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            fetch   = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            load_en = 1'($urandom_range(0, 1));
            go      = ($urandom_range(0, 7) == 0);
            halt    = ($urandom_range(0, 11) == 0);
            load_addr = 5'($urandom_range(0, 31));
            load_data = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7)       pc = 32'($urandom_range(0, 31) * 4);
            else if (sel == 7) pc = 32'($urandom_range(0, 127)) | 32'h1;
            else               pc = 32'($urandom_range(128, 65535));
            tick();
            checks++; if (inst !== m_inst) begin failures++; $display("FAIL rnd_inst c%0d got=%h exp=%h", i, inst, m_inst); end
            checks++; if (inst_valid !== m_valid) begin failures++; $display("FAIL rnd_valid c%0d got=%b exp=%b", i, inst_valid, m_valid); end
            checks++; if (fault !== m_fault) begin failures++; $display("FAIL rnd_fault c%0d got=%b exp=%b", i, fault, m_fault); end
            checks++; if (running !== m_run) begin failures++; $display("FAIL rnd_running c%0d got=%b exp=%b", i, running, m_run); end
            checks++; if (load_count !== 6'(m_cnt)) begin failures++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", i, load_count, m_cnt); end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load_go();
        test_back_to_back();
        test_fault();
        test_stall();
        test_run_load_ignored();
        test_saturate_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
